instr_fetch: RTL

- Front-end stage directly upstream of the decoder.
- Holds the PC and issues one-word instruction reads to the memory controller, one read in flight at a time.
- Buffers returned words with their PCs in a small instruction queue.
- Presents the queue head to the decoder as a one-cycle valid pulse per instruction, honouring the decoder's stall.
- On a redirect from the commit/branch logic: flushes the queue, discards any in-flight read, and refetches from the new PC.

---
 rtl/instr_fetch_pkg.sv | 23 ++
 rtl/instr_fetch_if.sv | 30 +++
 rtl/instr_fetch_fetch_queue.sv | 60 ++++++
 rtl/instr_fetch.sv | 107 ++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: FSM encodings, widths, queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  // Fetch FSM: at most one read outstanding; DROP retires a read whose
  // data is no longer wanted after a redirect.
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  // One instruction-queue entry, 64 bits: fetch PC and returned word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } iq_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: memory read port, decoder issue port, redirect, run enable.
// Latency: n/a (wires only).
// Backpressure: issue_stall from decoder; rdy freezes the fetch stage.
// master = fetch stage, slave = its environment (memory, decoder, commit logic).
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic            rdy;
  logic            mem_req_valid;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;
  logic            issue_stall;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    input  rdy, mem_resp_valid, mem_resp_data, issue_stall, redirect_valid, redirect_pc,
    output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output rdy, mem_resp_valid, mem_resp_data, issue_stall, redirect_valid, redirect_pc,
    input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc
  );

endinterface

// File: rtl/instr_fetch_fetch_queue.sv
// Circular FIFO of {pc, instr} entries feeding the decoder.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: full/count exported; caller never pushes when full nor pops when empty.
// Ports: push/push_data write tail, pop advances head, flush empties (wins over
// push/pop), head is the combinational head entry (stale when empty).
module fetch_queue
  import instr_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  iq_entry_t     push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output iq_entry_t     head
);

  iq_entry_t     mem_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // Storage is cleared so the head reads as zero straight out of reset.
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= push_data;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[head_q];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one read at a time, queues words, issues to decoder.
// Latency: request leaves the cycle IDLE is entered; a returned word reaches the decoder one cycle after its response.
// Backpressure: issue_stall holds the queue head; no request while the queue is full; rdy low freezes all state.
// Ports: clk, rst (sync, active-high), bus (master side of instr_fetch_if).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  localparam int unsigned CW = $clog2(IQ_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req;
  logic            issue;
  logic            q_push, q_pop, q_flush;
  logic            q_full, q_empty;
  logic [CW-1:0]   q_count;
  iq_entry_t       q_head;
  iq_entry_t       q_wdata;

  assign q_wdata.pc    = pc_q;
  assign q_wdata.instr = bus.mem_resp_data;

  fetch_queue #(.DEPTH(IQ_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (q_wdata),
    .pop       (q_pop),
    .flush     (q_flush),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .head      (q_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req     = 1'b0;
    issue   = 1'b0;
    q_push  = 1'b0;
    q_pop   = 1'b0;
    q_flush = 1'b0;
    if (!rst && bus.rdy) begin
      issue = !q_empty && !bus.issue_stall && !bus.redirect_valid;
      q_pop = issue;
      if (bus.redirect_valid) begin
        // Redirect beats push/pop; an outstanding read must still be retired
        // before a new one may go out, hence DROP unless it returns right now.
        pc_d    = bus.redirect_pc;
        q_flush = 1'b1;
        case (state_q)
          FS_WAIT, FS_DROP: state_d = bus.mem_resp_valid ? FS_IDLE : FS_DROP;
          default:          state_d = FS_IDLE;
        endcase
      end else begin
        case (state_q)
          FS_IDLE: begin
            if (q_count < CW'(IQ_DEPTH)) begin
              req     = 1'b1;
              state_d = FS_WAIT;
            end
          end
          FS_WAIT: begin
            if (bus.mem_resp_valid) begin
              q_push  = 1'b1;
              pc_d    = pc_q + PC_INC;
              state_d = FS_IDLE;
            end
          end
          FS_DROP: begin
            if (bus.mem_resp_valid) state_d = FS_IDLE;
          end
          default: state_d = FS_IDLE;
        endcase
      end
    end
  end

  assign bus.mem_req_valid = req;
  assign bus.mem_req_addr  = pc_q;
  assign bus.instr_valid   = issue;
  assign bus.instr         = q_head.instr;
  assign bus.instr_pc      = q_head.pc;

  // Single outstanding read plus the count gate means a push never lands on a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) (q_push && !q_pop) |-> !q_full);

endmodule
